// File: rtl/device_serial_tx.sv
// UART-style serial transmitter fed from two register-file slots (data byte, control byte).
// A frame is requested by flipping bit 0 of the control slot; extra requests mid-frame queue one follow-on frame.
module device_serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  tx_data,
    input  logic [DATA_WIDTH-1:0]  tx_ctrl,
    output logic                   serial_out,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] frames_sent
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 r_state, w_state_nxt;
    logic [BAUD_W-1:0]      r_baud, w_baud_nxt;
    logic [IDX_W-1:0]       r_idx, w_idx_nxt;
    logic [DATA_WIDTH-1:0]  r_shift, w_shift_nxt;
    logic                   r_parity, w_parity_nxt;
    logic                   r_parity_en, w_parity_en_nxt;
    logic                   r_two_stop, w_two_stop_nxt;
    logic                   r_pending, w_pending_nxt;
    logic                   r_serial, w_serial_nxt;
    logic                   r_busy, w_busy_nxt;
    logic [COUNT_WIDTH-1:0] r_frames, w_frames_nxt;
    logic                   r_last_toggle;
    logic                   w_req;
    logic                   w_bit_end;

    generate
        if (DATA_WIDTH > 3) begin : g_unused
            logic w_unused_ctrl;
            assign w_unused_ctrl = ^tx_ctrl[DATA_WIDTH-1:3];
        end
    endgenerate

    assign w_req     = tx_ctrl[0] ^ r_last_toggle;
    assign w_bit_end = (r_baud == LAST_BAUD);

    assign serial_out  = r_serial;
    assign busy        = r_busy;
    assign frames_sent = r_frames;

    always_comb begin
        w_state_nxt     = r_state;
        w_baud_nxt      = w_bit_end ? '0 : r_baud + 1'b1;
        w_idx_nxt       = r_idx;
        w_shift_nxt     = r_shift;
        w_parity_nxt    = r_parity;
        w_parity_en_nxt = r_parity_en;
        w_two_stop_nxt  = r_two_stop;
        w_pending_nxt   = r_pending | (w_req && (r_state != IDLE));
        w_serial_nxt    = r_serial;
        w_busy_nxt      = r_busy;
        w_frames_nxt    = r_frames;

        case (r_state)
            IDLE: begin
                w_baud_nxt   = '0;
                w_serial_nxt = 1'b1;
                if (w_req) begin
                    w_shift_nxt     = tx_data;
                    w_parity_en_nxt = tx_ctrl[1];
                    w_two_stop_nxt  = tx_ctrl[2];
                    w_parity_nxt    = 1'b0;
                    w_state_nxt     = START;
                    w_serial_nxt    = 1'b0;
                    w_busy_nxt      = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt  = DATA;
                    w_idx_nxt    = '0;
                    w_serial_nxt = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_parity_nxt = r_parity ^ r_shift[0];
                    w_shift_nxt  = r_shift >> 1;
                    w_idx_nxt    = r_idx + 1'b1;
                    w_serial_nxt = w_shift_nxt[0];
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt = '0;
                        if (r_parity_en) begin
                            w_state_nxt  = PARITY;
                            w_serial_nxt = w_parity_nxt;
                        end else begin
                            w_state_nxt  = STOP;
                            w_serial_nxt = 1'b1;
                        end
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt  = STOP;
                    w_idx_nxt    = '0;
                    w_serial_nxt = 1'b1;
                end
            end
            STOP: begin
                // r_idx counts completed stop-bit periods when two stop bits are selected
                if (w_bit_end) begin
                    if (r_two_stop && (r_idx == '0)) begin
                        w_idx_nxt = IDX_W'(1);
                    end else begin
                        w_frames_nxt = r_frames + 1'b1;
                        if (r_pending || w_req) begin
                            w_pending_nxt   = 1'b0;
                            w_shift_nxt     = tx_data;
                            w_parity_en_nxt = tx_ctrl[1];
                            w_two_stop_nxt  = tx_ctrl[2];
                            w_parity_nxt    = 1'b0;
                            w_state_nxt     = START;
                            w_serial_nxt    = 1'b0;
                        end else begin
                            w_state_nxt  = IDLE;
                            w_busy_nxt   = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_serial_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        r_last_toggle <= tx_ctrl[0];
        if (reset) begin
            r_state     <= IDLE;
            r_baud      <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_parity_en <= 1'b0;
            r_two_stop  <= 1'b0;
            r_pending   <= 1'b0;
            r_serial    <= 1'b1;
            r_busy      <= 1'b0;
            r_frames    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_baud      <= w_baud_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_parity    <= w_parity_nxt;
            r_parity_en <= w_parity_en_nxt;
            r_two_stop  <= w_two_stop_nxt;
            r_pending   <= w_pending_nxt;
            r_serial    <= w_serial_nxt;
            r_busy      <= w_busy_nxt;
            r_frames    <= w_frames_nxt;
        end
    end

endmodule

// File: tb/tb_device_serial_tx.sv
// Bench for device_serial_tx: a waveform-queue model checked every cycle, plus directed literal checks.
module tb_device_serial_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] tx_ctrl;
    logic          serial_out;
    logic          busy;
    logic [CW-1:0] frames_sent;

    int npass  = 0;
    int ntotal = 0;
    logic chk_en = 1'b0;

    device_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_ctrl(tx_ctrl),
        .serial_out(serial_out), .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: each started frame is expanded into its per-cycle line levels; the queue head is the current level.
    bit            mq[$];
    logic          m_pending = 1'b0;
    logic          m_last    = 1'b0;
    logic [CW-1:0] m_frames  = '0;

    function automatic void build(input logic [DW-1:0] d, input logic [DW-1:0] c);
        repeat (CPB) mq.push_back(1'b0);
        for (int i = 0; i < DW; i++) repeat (CPB) mq.push_back(d[i]);
        if (c[1]) repeat (CPB) mq.push_back(^d);
        repeat (CPB * (c[2] ? 2 : 1)) mq.push_back(1'b1);
    endfunction

    always @(posedge clk) begin
        logic req;
        if (reset) begin
            mq.delete();
            m_pending = 1'b0;
            m_frames  = '0;
            m_last    = tx_ctrl[0];
        end else begin
            req    = (tx_ctrl[0] != m_last);
            m_last = tx_ctrl[0];
            if (mq.size() == 0) begin
                if (req) build(tx_data, tx_ctrl);
            end else begin
                if (req) m_pending = 1'b1;
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    m_frames = m_frames + 1'b1;
                    if (m_pending) begin
                        m_pending = 1'b0;
                        build(tx_data, tx_ctrl);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_serial", {31'b0, serial_out}, {31'b0, (mq.size() != 0) ? mq[0] : 1'b1});
            chk("model_busy",   {31'b0, busy},       {31'b0, mq.size() != 0});
            chk("model_frames", {30'b0, frames_sent}, {30'b0, m_frames});
        end
    end

    task automatic toggle(input logic [DW-1:0] d, input logic [1:0] cfg);
        tx_data = d;
        tx_ctrl = {5'b0, cfg, ~tx_ctrl[0]};
    endtask

    // Starts a frame at the current negedge and watches ncyc cycles; samples mid-bit into pat.
    task automatic send_watch(input logic [DW-1:0] d, input logic [1:0] cfg, input int mod_cyc,
                              input logic [DW-1:0] mod_data, input int ncyc,
                              output int bcnt, output logic [15:0] pat);
        bcnt = 0;
        pat  = '0;
        toggle(d, cfg);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if ((c % CPB == 1) && (c < 16 * CPB)) pat = {pat[14:0], serial_out};
            if (c == mod_cyc) tx_data = mod_data;
        end
    endtask

    initial begin
        int          bcnt;
        logic [15:0] pat;
        logic [9:0]  pat2;
        logic [CW-1:0] wrap_exp [5];
        logic [31:0] r;
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset = 1'b1; tx_data = '0; tx_ctrl = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_serial", {31'b0, serial_out}, 32'd1);
        chk("rst_busy",   {31'b0, busy},       32'd0);
        chk("rst_frames", {30'b0, frames_sent}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        send_watch(8'hA5, 2'b00, -1, 8'h00, 64, bcnt, pat);
        chk("basic_pat",    {16'b0, pat}, {16'b0, 16'b0101001011_111111});
        chk("basic_busy",   bcnt, 40);
        chk("basic_frames", {30'b0, frames_sent}, 32'd1);

        send_watch(8'h07, 2'b11, -1, 8'h00, 64, bcnt, pat);
        chk("par_pat",    {16'b0, pat}, {16'b0, 16'b011100000111_1111});
        chk("par_busy",   bcnt, 48);
        chk("par_frames", {30'b0, frames_sent}, 32'd2);

        send_watch(8'h00, 2'b00, 6, 8'hFF, 64, bcnt, pat);
        chk("iso_pat",  {16'b0, pat}, {16'b0, 16'b0000000001_111111});
        chk("iso_busy", bcnt, 40);

        toggle(8'h5A, 2'b00);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_serial", {31'b0, serial_out}, 32'd1);
        chk("midrst_busy",   {31'b0, busy},       32'd0);
        chk("midrst_frames", {30'b0, frames_sent}, 32'd0);
        reset = 1'b0;
        bcnt = 0;
        repeat (50) begin @(negedge clk); if (busy || !serial_out) bcnt++; end
        chk("midrst_quiet", bcnt, 0);

        reset = 1'b1; tx_ctrl = 8'h01;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bcnt = 0;
        repeat (30) begin @(negedge clk); if (busy || !serial_out) bcnt++; end
        chk("immune_quiet", bcnt, 0);

        bcnt = 0; pat2 = '0;
        toggle(8'h11, 2'b00);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if ((c % CPB == 1) && c >= 40 && c < 80) pat2 = {pat2[8:0], serial_out};
            if (c == 5) toggle(8'h3C, 2'b00);
            if (c == 9 || c == 13) tx_ctrl[0] = ~tx_ctrl[0];
        end
        chk("pend_busy",   bcnt, 80);
        chk("pend_pat",    {22'b0, pat2}, {22'b0, 10'b0001111001});
        chk("pend_frames", {30'b0, frames_sent}, 32'd2);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            r = $urandom;
            send_watch(r[7:0], r[9:8], -1, 8'h00, 64, bcnt, pat);
            chk("wrap_frames", {30'b0, frames_sent}, {30'b0, wrap_exp[k]});
        end

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = $urandom;
            reset = (r[15:8] == 8'd0);
            if (r[2:0] == 3'd0) begin
                tx_data = r[31:24];
                tx_ctrl = {r[23:17], ~tx_ctrl[0]};
            end else if (r[4:3] == 2'd0) begin
                tx_data = r[31:24];
            end
        end
        reset = 1'b0;
        repeat (120) @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
